// File: rtl/uart_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// uart_cmd_sequencer
//
// Parses the UART RX byte stream for the clock/alarm design and turns it into
// configuration writes for the time counter and the alarm register. Every
// command that is recognised produces one response byte toward the UART TX
// path: '+' (ack) or '!' (nack).
//
// Commands (letters are case-insensitive):
//   l MMSS CR   load the time counter from ld_value
//   a MMSS CR   load the alarm register from ld_value
//   e           enable the alarm
//   d           disable the alarm
//
// Parameters
//   TIMEOUT_CYC  clk12m cycles allowed between bytes inside a command
//   TO_W         width of the inter-byte timeout counter
//
// Ports
//   clk12m       in   12 MHz system clock
//   rst_n        in   asynchronous active-low reset
//   rx_data      in   received byte, valid only while rx_data_rdy=1
//   rx_data_rdy  in   one-cycle strobe, byte available
//   tx_busy      in   UART TX cannot accept a byte this cycle
//   tx_data      out  ack/nack byte, held until tx_data_rdy
//   tx_data_rdy  out  one-cycle strobe, tx_data valid
//   ld_time      out  one-cycle pulse, load time counter from ld_value
//   ld_alarm     out  one-cycle pulse, load alarm register from ld_value
//   ld_value     out  {Mtens,Mones,Stens,Sones}, BCD
//   alarm_en     out  alarm enable level
//   cmd_err      out  one-cycle pulse on any aborted command
// -----------------------------------------------------------------------------
module uart_cmd_sequencer #(
  parameter int unsigned TIMEOUT_CYC = 12000000,
  parameter int unsigned TO_W        = 24
) (
  input  logic        clk12m,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_rdy,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_data_rdy,
  output logic        ld_time,
  output logic        ld_alarm,
  output logic [15:0] ld_value,
  output logic        alarm_en,
  output logic        cmd_err
);

  localparam logic [7:0]      CHAR_CR   = 8'h0d;
  localparam logic [7:0]      CHAR_ACK  = 8'h2b;  // '+'
  localparam logic [7:0]      CHAR_NACK = 8'h21;  // '!'
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIG,
    S_WCR,
    S_RESP
  } state_e;

  state_e          state_q,    state_d;
  logic [1:0]      idx_q,      idx_d;       // digit index inside S_DIG
  logic            tgt_alarm_q, tgt_alarm_d; // 1: alarm register, 0: time counter
  logic [15:0]     shadow_q,   shadow_d;    // digits collected before the CR commits them
  logic [15:0]     ld_value_q, ld_value_d;
  logic [TO_W-1:0] to_q,       to_d;
  logic [7:0]      tx_data_q,  tx_data_d;
  logic            alarm_en_q, alarm_en_d;
  logic            ld_time_q,  ld_time_d;
  logic            ld_alarm_q, ld_alarm_d;
  logic            cmd_err_q,  cmd_err_d;

  // Byte classification.
  logic       is_load_time;
  logic       is_load_alarm;
  logic       is_enable;
  logic       is_disable;
  logic [7:0] digit_max;
  logic       digit_ok;

  always_comb begin
    is_load_time  = (rx_data == 8'h6c) || (rx_data == 8'h4c);  // 'l' / 'L'
    is_load_alarm = (rx_data == 8'h61) || (rx_data == 8'h41);  // 'a' / 'A'
    is_enable     = (rx_data == 8'h65) || (rx_data == 8'h45);  // 'e' / 'E'
    is_disable    = (rx_data == 8'h64) || (rx_data == 8'h44);  // 'd' / 'D'
    // Tens positions (index 0 and 2) stop at '5', ones positions at '9'.
    digit_max     = idx_q[0] ? 8'h39 : 8'h35;
    digit_ok      = (rx_data >= 8'h30) && (rx_data <= digit_max);
  end

  logic abort;

  always_comb begin
    // NOTE: every variable assigned in this block gets a default first so no
    // path through the case/if tree can leave it unassigned and infer a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    tgt_alarm_d = tgt_alarm_q;
    shadow_d    = shadow_q;
    ld_value_d  = ld_value_q;
    to_d        = to_q;
    tx_data_d   = tx_data_q;
    alarm_en_d  = alarm_en_q;
    ld_time_d   = 1'b0;
    ld_alarm_d  = 1'b0;
    cmd_err_d   = 1'b0;
    abort       = 1'b0;

    // Inter-byte timeout: only ticks while a command is in progress and no
    // byte arrives. A byte in the expiry cycle wins and clears the counter.
    if ((state_q == S_DIG || state_q == S_WCR) && !rx_data_rdy) begin
      if (to_q == TO_LAST) begin
        abort = 1'b1;
      end else begin
        to_d = to_q + TO_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (rx_data_rdy) begin
          if (is_load_time || is_load_alarm) begin
            tgt_alarm_d = is_load_alarm;
            idx_d       = 2'd0;
            shadow_d    = 16'h0000;
            to_d        = '0;
            state_d     = S_DIG;
          end else if (is_enable || is_disable) begin
            alarm_en_d = is_enable;
            tx_data_d  = CHAR_ACK;
            state_d    = S_RESP;
          end
        end
      end

      S_DIG: begin
        if (rx_data_rdy) begin
          to_d = '0;
          if (digit_ok) begin
            case (idx_q)
              2'd0:    shadow_d[15:12] = rx_data[3:0];
              2'd1:    shadow_d[11:8]  = rx_data[3:0];
              2'd2:    shadow_d[7:4]   = rx_data[3:0];
              default: shadow_d[3:0]   = rx_data[3:0];
            endcase
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              state_d = S_WCR;
            end
          end else begin
            abort = 1'b1;
          end
        end
      end

      S_WCR: begin
        if (rx_data_rdy) begin
          to_d = '0;
          if (rx_data == CHAR_CR) begin
            ld_value_d = shadow_q;
            ld_time_d  = !tgt_alarm_q;
            ld_alarm_d = tgt_alarm_q;
            tx_data_d  = CHAR_ACK;
            state_d    = S_RESP;
          end else begin
            abort = 1'b1;
          end
        end
      end

      S_RESP: begin
        // Any byte arriving here is dropped silently.
        if (!tx_busy) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Abort leaves ld_value untouched and throws the collected digits away.
    if (abort) begin
      cmd_err_d = 1'b1;
      shadow_d  = 16'h0000;
      to_d      = '0;
      tx_data_d = CHAR_NACK;
      state_d   = S_RESP;
    end
  end

  always_ff @(posedge clk12m or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= 2'd0;
      tgt_alarm_q <= 1'b0;
      shadow_q    <= 16'h0000;
      ld_value_q  <= 16'h0000;
      to_q        <= '0;
      tx_data_q   <= 8'h00;
      alarm_en_q  <= 1'b0;
      ld_time_q   <= 1'b0;
      ld_alarm_q  <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed from the previous state, independent of statement order.
      state_q     <= state_d;
      idx_q       <= idx_d;
      tgt_alarm_q <= tgt_alarm_d;
      shadow_q    <= shadow_d;
      ld_value_q  <= ld_value_d;
      to_q        <= to_d;
      tx_data_q   <= tx_data_d;
      alarm_en_q  <= alarm_en_d;
      ld_time_q   <= ld_time_d;
      ld_alarm_q  <= ld_alarm_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  // The response strobe fires in the first RESP cycle the TX path is free.
  assign tx_data_rdy = (state_q == S_RESP) && !tx_busy;
  assign tx_data     = tx_data_q;
  assign ld_time     = ld_time_q;
  assign ld_alarm    = ld_alarm_q;
  assign ld_value    = ld_value_q;
  assign alarm_en    = alarm_en_q;
  assign cmd_err     = cmd_err_q;

endmodule
